// File: rtl/fan_duty_ramp_pkg.sv
// Shared fan-control types and constants.
// Used by the duty ramp, PWM and IR timeout blocks.
package fan_pkg;

  localparam int DUTY_W = 6;

  localparam logic [DUTY_W-1:0] LVL_OFF  = 6'd0;
  localparam logic [DUTY_W-1:0] LVL_LOW  = 6'd21;
  localparam logic [DUTY_W-1:0] LVL_MED  = 6'd42;
  localparam logic [DUTY_W-1:0] LVL_HIGH = 6'd63;

  localparam int STEP_TICKS = 1_000_000;
  localparam int KICK_TICKS = 20_000_000;

  typedef enum logic [1:0] {
    IDLE,
    KICK,
    RAMP,
    HOLD
  } state_t;

  // Widened arithmetic so neither direction can wrap.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W:0]   step
  );
    logic [DUTY_W:0] c;
    logic [DUTY_W:0] t;
    logic [DUTY_W:0] n;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c)
      n = (t - c <= step) ? t : c + step;
    else
      n = (c - t <= step) ? t : c - step;
    return n[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/fan_duty_ramp_if.sv
// Duty request/response bundle between the selector,
// the ramp stage and the PWM generator.
interface fan_duty_ramp_if;
  import fan_pkg::*;

  logic [DUTY_W-1:0] target_duty;
  logic              estop;
  logic [DUTY_W-1:0] duty_out;
  logic              busy;
  logic              at_target;

  modport master (
    output target_duty,
    output estop,
    input  duty_out,
    input  busy,
    input  at_target
  );

  modport slave (
    input  target_duty,
    input  estop,
    output duty_out,
    output busy,
    output at_target
  );
endinterface

// File: rtl/fan_step_tick.sv
// Modulo-N counter with sync clear and enable;
// tc pulses for one cycle on the terminal count.
module fan_step_tick #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= '0;
    else if (en)
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign tc = en && !clr && (cnt_q == LAST);
endmodule

// File: rtl/fan_duty_ramp.sv
// Soft-start and slew limiter between the fan speed
// selector and the PWM generator.
module fan_duty_ramp
  import fan_pkg::*;
#(
  parameter int STEP_TICKS = fan_pkg::STEP_TICKS,
  parameter int STEP_SIZE  = 1,
  parameter int KICK_DUTY  = 63,
  parameter int KICK_TICKS = fan_pkg::KICK_TICKS
) (
  input logic             clk,
  input logic             reset_n,
  fan_duty_ramp_if.slave  bus
);
  localparam logic [DUTY_W-1:0] KICK_VAL = DUTY_W'(KICK_DUTY);
  localparam logic [DUTY_W:0]   STEP_VAL = (DUTY_W+1)'(STEP_SIZE);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] stepped;
  logic              kick_clr, kick_en, kick_tc;
  logic              step_clr, step_en, step_tc;

  fan_step_tick #(.N(KICK_TICKS)) u_kick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (kick_clr),
    .en      (kick_en),
    .tc      (kick_tc)
  );

  fan_step_tick #(.N(STEP_TICKS)) u_step (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (step_clr),
    .en      (step_en),
    .tc      (step_tc)
  );

  assign stepped = step_toward(duty_q, bus.target_duty, STEP_VAL);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    kick_clr = 1'b1;
    kick_en  = 1'b0;
    step_clr = 1'b1;
    step_en  = 1'b0;
    if (bus.estop) begin
      state_d = IDLE;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.target_duty != '0) begin
            state_d = KICK;
            duty_d  = KICK_VAL;
          end
        end
        KICK: begin
          kick_clr = 1'b0;
          kick_en  = 1'b1;
          if (bus.target_duty == '0) begin
            state_d = IDLE;
            duty_d  = '0;
          end else if (kick_tc) begin
            state_d = HOLD;
            duty_d  = bus.target_duty;
          end
        end
        HOLD: begin
          if (bus.target_duty != duty_q)
            state_d = RAMP;
        end
        RAMP: begin
          if (bus.target_duty == duty_q) begin
            state_d = (duty_q != '0) ? HOLD : IDLE;
          end else begin
            step_clr = 1'b0;
            step_en  = 1'b1;
            if (step_tc) begin
              duty_d = stepped;
              if (stepped == bus.target_duty)
                state_d = (stepped != '0) ? HOLD : IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  assign bus.duty_out  = duty_q;
  assign bus.busy      = (state_q == KICK) || (state_q == RAMP);
  assign bus.at_target = (duty_q == bus.target_duty) && (state_q != KICK);
endmodule

// File: tb/tb_fan_duty_ramp.sv
// Randomised scoreboard bench for fan_duty_ramp
// against a behavioural soft-start/slew model.
module tb_fan_duty_ramp;
  localparam int ST = 4;
  localparam int KT = 8;
  localparam int SS = 1;
  localparam int KD = 63;

  typedef struct packed {
    logic [5:0] duty;
    logic       busy;
    logic       at;
  } exp_t;

  typedef enum int {M_OFF, M_KICK, M_SLEW, M_STEADY} mode_e;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  fan_duty_ramp_if bus ();

  fan_duty_ramp #(
    .STEP_TICKS (ST),
    .STEP_SIZE  (SS),
    .KICK_DUTY  (KD),
    .KICK_TICKS (KT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$];
  mode_e m_mode = M_OFF;
  int    m_duty = 0;
  int    kick_age = 0;
  int    slew_age = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, req, $time);
    end
  endtask

  // One clock edge of the soft-start/slew behaviour.
  task automatic model_edge(int t, bit e);
    int gap;
    if (e) begin
      m_mode = M_OFF;
      m_duty = 0;
      return;
    end
    case (m_mode)
      M_OFF:
        if (t != 0) begin
          m_mode = M_KICK;
          m_duty = KD;
          kick_age = 0;
        end
      M_KICK:
        if (t == 0) begin
          m_mode = M_OFF;
          m_duty = 0;
        end else begin
          kick_age++;
          if (kick_age == KT) begin
            m_duty = t;
            m_mode = M_STEADY;
          end
        end
      M_STEADY:
        if (t != m_duty) begin
          m_mode = M_SLEW;
          slew_age = 0;
        end
      M_SLEW: begin
        if (t == m_duty) begin
          m_mode = (t != 0) ? M_STEADY : M_OFF;
        end else begin
          slew_age++;
          if (slew_age % ST == 0) begin
            gap = (t > m_duty) ? t - m_duty : m_duty - t;
            if (gap > SS) gap = SS;
            m_duty += (t > m_duty) ? gap : -gap;
            if (m_duty == t)
              m_mode = (t != 0) ? M_STEADY : M_OFF;
          end
        end
      end
      default: m_mode = M_OFF;
    endcase
  endtask

  task automatic run(int t, bit e, int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.target_duty = 6'(t);
      bus.estop = e;
      model_edge(t, e);
      x.duty = 6'(m_duty);
      x.busy = (m_mode == M_KICK) || (m_mode == M_SLEW);
      x.at   = (m_duty == t) && (m_mode != M_KICK);
      sb.push_back(x);
    end
  endtask

  task automatic run_until(int t, int duty, int limit);
    int n = 0;
    while (m_duty != duty && n < limit) begin
      run(t, 1'b0, 1);
      n++;
    end
    if (m_duty != duty) begin
      errors++;
      $display("FAIL wait_duty: timeout, duty %0d not %0d",
               m_duty, duty);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_duty", int'(bus.duty_out), 0);
    check("async_busy", int'(bus.busy), 0);
    m_mode = M_OFF;
    m_duty = 0;
    #1 reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("duty_out", int'(bus.duty_out), int'(x.duty));
        check("busy", int'(bus.busy), int'(x.busy));
        check("at_target", int'(bus.at_target), int'(x.at));
      end
    end
  end

  initial begin : driver
    int lv;
    int levels[4] = '{0, 21, 42, 63};
    bus.target_duty = '0;
    bus.estop = 1'b0;
    #3;
    check("rst_duty", int'(bus.duty_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_at", int'(bus.at_target), 1);
    @(negedge clk);
    reset_n = 1'b1;

    run(0, 0, 3);
    run(21, 0, 12);
    run(42, 0, 90);
    run(0, 0, 180);
    run(21, 0, 12);
    run_until(42, 30, 100);
    run(21, 0, 50);
    run_until(42, 35, 100);
    run(42, 1, 6);
    run(42, 0, 20);
    run(42, 1, 1);
    run(21, 0, 3);
    run(0, 0, 3);
    run(63, 0, 4);
    async_reset();
    run(0, 0, 2);
    run(42, 0, 15);

    for (int i = 0; i < 60; i++) begin
      lv = levels[$urandom_range(0, 3)];
      run(lv, ($urandom_range(0, 19) == 0), $urandom_range(1, 40));
    end
    run(0, 0, 300);

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
